// File: rtl/sinegen_pkg.sv
// sinegen_pkg: shared state encoding and address-mux selects for the sine ROM sequencer.
package sinegen_pkg;

    // Sequencer states: waiting for a command, issuing addresses, flushing the last sample.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Address mux selects: the live accumulator slice, or the address of the sample
    // currently on the ROM outputs (re-read while stalled or draining).
    localparam logic ADDR_SEL_ACC  = 1'b0;
    localparam logic ADDR_SEL_HELD = 1'b1;

endpackage

// File: rtl/phase_acc.sv
// phase_acc: fractional phase accumulator; the ROM address is its top ADDRESS_WIDTH bits.
module phase_acc
    import sinegen_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int ACC_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_zero,
    input  logic                     advance,
    input  logic [ACC_WIDTH-1:0]     step,
    output logic [ADDRESS_WIDTH-1:0] addr
);

    logic [ACC_WIDTH-1:0] acc;

    // Clear at the start of a run, then add one step per issued sample; overflow wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (load_zero) begin
            acc <= '0;
        end else if (advance) begin
            acc <= acc + step;
        end
    end

    assign addr = acc[ACC_WIDTH-1 -: ADDRESS_WIDTH];

endmodule

// File: rtl/sinegen_ctrl.sv
// sinegen_ctrl: turns a start command into a stream of sine ROM addresses and tags the
// ROM's registered outputs with a valid/ready handshake that tolerates downstream stalls.
module sinegen_ctrl
    import sinegen_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int ACC_WIDTH     = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ACC_WIDTH-1:0]     step,
    input  logic [ADDRESS_WIDTH-1:0] phase,
    input  logic [CNT_WIDTH-1:0]     count,
    input  logic                     stop,
    input  logic                     ready,
    output logic [ADDRESS_WIDTH-1:0] addr1,
    output logic [ADDRESS_WIDTH-1:0] offset,
    output logic                     valid,
    output logic                     busy,
    output logic                     done
);

    state_t                   state;
    logic [ACC_WIDTH-1:0]     step_q;
    logic [CNT_WIDTH-1:0]     count_q;
    logic [CNT_WIDTH-1:0]     issue_cnt;
    logic [ADDRESS_WIDTH-1:0] held_addr;
    logic [ADDRESS_WIDTH-1:0] acc_addr;
    logic                     stall;
    logic                     issue;
    logic                     last_issue;
    logic                     load_zero;
    logic                     addr_sel;

    // A sample sitting on the ROM outputs that downstream refuses must be held there.
    assign stall = valid && !ready;

    // A new address goes out only while running, not stopping, and not holding a refused sample.
    assign issue = (state == RUN) && !stop && !stall;

    // Final issue of a finite burst; count of zero means run until stopped.
    assign last_issue = issue && (count_q != '0) && (issue_cnt == count_q - CNT_WIDTH'(1));

    assign load_zero = (state == IDLE) && start;

    // Re-read the displayed sample's address whenever it must stay on the ROM outputs.
    assign addr_sel = (stall || (state == DRAIN)) ? ADDR_SEL_HELD : ADDR_SEL_ACC;
    assign addr1    = (addr_sel == ADDR_SEL_HELD) ? held_addr : acc_addr;

    assign busy = (state != IDLE);

    phase_acc #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .ACC_WIDTH     (ACC_WIDTH)
    ) u_phase_acc (
        .clk       (clk),
        .rst       (rst),
        .load_zero (load_zero),
        .advance   (issue),
        .step      (step_q),
        .addr      (acc_addr)
    );

    // Sequencer FSM with command latching, issue counter, held address, valid and done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step_q    <= '0;
            count_q   <= '0;
            offset    <= '0;
            issue_cnt <= '0;
            held_addr <= '0;
            valid     <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        state     <= RUN;
                        step_q    <= step;
                        offset    <= phase;
                        count_q   <= count;
                        issue_cnt <= '0;
                    end
                end
                RUN: begin
                    valid <= issue || stall;
                    if (issue) begin
                        held_addr <= acc_addr;
                        if (issue_cnt != '1) begin
                            issue_cnt <= issue_cnt + CNT_WIDTH'(1);
                        end
                    end
                    if (stop || last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!valid || ready) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        valid <= stall;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sinegen_ctrl.sv
// tb_sinegen_ctrl: self-checking bench for sinegen_ctrl with a registered dual-port ROM model.
module tb_sinegen_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] step;
    logic [7:0]  phase;
    logic [15:0] count;
    logic        stop;
    logic        ready;
    logic [7:0]  addr1;
    logic [7:0]  offset;
    logic        valid;
    logic        busy;
    logic        done;
    logic [7:0]  dout1;
    logic [7:0]  dout2;
    logic [7:0]  addr2;

    int checks = 0;
    int passes = 0;

    sinegen_ctrl #(
        .ADDRESS_WIDTH (8),
        .ACC_WIDTH     (16),
        .CNT_WIDTH     (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .step   (step),
        .phase  (phase),
        .count  (count),
        .stop   (stop),
        .ready  (ready),
        .addr1  (addr1),
        .offset (offset),
        .valid  (valid),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // ROM contents: a bijection of the address so distinct addresses give distinct words.
    function automatic logic [7:0] rom_word(input logic [7:0] a);
        return {a[2:0], a[7:3]} ^ 8'h5A;
    endfunction

    // Reference: sample k reads the top byte of (k * step) mod 2^16.
    function automatic logic [7:0] model_addr(input int unsigned k, input logic [15:0] stp);
        logic [31:0] prod;
        prod = k * stp;
        return prod[15:8];
    endfunction

    // Registered dual-port ROM: one-cycle read latency, port 2 reads addr1 + offset.
    assign addr2 = addr1 + offset;
    always @(posedge clk) begin
        dout1 <= rom_word(addr1);
        dout2 <= rom_word(addr2);
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; ready = 1'b0;
        step = '0; phase = '0; count = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0; ready = 1'b1;
        #1;
        checks++;
        if (addr1 !== 8'h00) $display("[TB] FAIL reset_addr1: got %0h expected 0", addr1); else passes++;
        checks++;
        if (offset !== 8'h00) $display("[TB] FAIL reset_offset: got %0h expected 0", offset); else passes++;
        checks++;
        if (valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", valid); else passes++;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", busy); else passes++;
        checks++;
        if (done !== 1'b0) $display("[TB] FAIL reset_done: got %0b expected 0", done); else passes++;
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL idle_stop_busy: got %0b expected 0", busy); else passes++;
        checks++;
        if (done !== 1'b0) $display("[TB] FAIL idle_stop_done: got %0b expected 0", done); else passes++;
    endtask

    task automatic run_burst(input string name, input logic [15:0] stp, input logic [7:0] ph, input int n);
        logic [7:0] exp_a;
        logic       exp_v;
        @(negedge clk);
        start = 1'b1; step = stp; phase = ph; count = 16'(n); ready = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL %s_busy_T: got %0b expected 0", name, busy); else passes++;
        for (int k = 1; k <= n + 3; k++) begin
            @(negedge clk);
            start = 1'b0; step = 16'($urandom); phase = 8'($urandom); count = 16'($urandom);
            #1;
            if (k <= n + 1) begin
                exp_a = (k <= n) ? model_addr(k - 1, stp) : model_addr(n - 1, stp);
                checks++;
                if (addr1 !== exp_a) $display("[TB] FAIL %s_addr1 k=%0d: got %0h expected %0h", name, k, addr1, exp_a); else passes++;
                checks++;
                if (offset !== ph) $display("[TB] FAIL %s_offset k=%0d: got %0h expected %0h", name, k, offset, ph); else passes++;
            end
            exp_v = (k >= 2) && (k <= n + 1);
            checks++;
            if (valid !== exp_v) $display("[TB] FAIL %s_valid k=%0d: got %0b expected %0b", name, k, valid, exp_v); else passes++;
            if (exp_v) begin
                checks++;
                if (dout1 !== rom_word(model_addr(k - 2, stp)))
                    $display("[TB] FAIL %s_dout1 k=%0d: got %0h expected %0h", name, k, dout1, rom_word(model_addr(k - 2, stp)));
                else passes++;
                checks++;
                if (dout2 !== rom_word(model_addr(k - 2, stp) + ph))
                    $display("[TB] FAIL %s_dout2 k=%0d: got %0h expected %0h", name, k, dout2, rom_word(model_addr(k - 2, stp) + ph));
                else passes++;
            end
            checks++;
            if (done !== (k == n + 2)) $display("[TB] FAIL %s_done k=%0d: got %0b expected %0b", name, k, done, (k == n + 2)); else passes++;
            checks++;
            if (busy !== (k <= n + 1)) $display("[TB] FAIL %s_busy k=%0d: got %0b expected %0b", name, k, busy, (k <= n + 1)); else passes++;
        end
    endtask

    task automatic test_burst();
        run_burst("burst", 16'h0100, 8'h40, 4);
    endtask

    task automatic test_fractional_wrap();
        run_burst("frac", 16'h0180, 8'($urandom), 6);
        run_burst("wrap", 16'hC000, 8'($urandom), 3);
    endtask

    task automatic test_backpressure();
        logic [7:0] got_q[$];
        int         done_k;
        int         k;
        done_k = 0;
        k = 0;
        @(negedge clk);
        start = 1'b1; step = 16'h0100; phase = 8'h10; count = 16'd4; ready = 1'b1;
        while (done_k == 0 && k < 40) begin
            k++;
            @(negedge clk);
            start = 1'b0;
            ready = !(k >= 3 && k <= 5);
            #1;
            if (k >= 3 && k <= 5) begin
                checks++;
                if (addr1 !== 8'h01) $display("[TB] FAIL bp_addr1 k=%0d: got %0h expected 1", k, addr1); else passes++;
                checks++;
                if (valid !== 1'b1) $display("[TB] FAIL bp_valid k=%0d: got %0b expected 1", k, valid); else passes++;
                checks++;
                if (dout1 !== rom_word(8'h01)) $display("[TB] FAIL bp_dout1 k=%0d: got %0h expected %0h", k, dout1, rom_word(8'h01)); else passes++;
            end
            if (valid && ready) got_q.push_back(dout1);
            if (done) done_k = k;
        end
        checks++;
        if (done_k != 9) $display("[TB] FAIL bp_done_cycle: got %0d expected 9", done_k); else passes++;
        checks++;
        if (got_q.size() != 4) $display("[TB] FAIL bp_accept_count: got %0d expected 4", got_q.size()); else passes++;
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            checks++;
            if (got_q[i] !== rom_word(model_addr(i, 16'h0100)))
                $display("[TB] FAIL bp_accept[%0d]: got %0h expected %0h", i, got_q[i], rom_word(model_addr(i, 16'h0100)));
            else passes++;
        end
    endtask

    task automatic test_continuous_stop();
        logic [15:0] stp;
        logic [7:0]  ph;
        int unsigned idx;
        stp = 16'h0100 + 16'($urandom_range(0, 255));
        ph  = 8'($urandom);
        idx = 0;
        @(negedge clk);
        start = 1'b1; step = stp; phase = ph; count = 16'd0; ready = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start = (k == 150);
            step  = 16'($urandom);
            phase = 8'($urandom);
            #1;
            checks++;
            if (valid !== (k >= 2)) $display("[TB] FAIL cont_valid k=%0d: got %0b expected %0b", k, valid, (k >= 2)); else passes++;
            if (valid && ready) begin
                checks++;
                if (dout1 !== rom_word(model_addr(idx, stp)))
                    $display("[TB] FAIL cont_dout1 idx=%0d: got %0h expected %0h", idx, dout1, rom_word(model_addr(idx, stp)));
                else passes++;
                idx++;
            end
        end
        @(negedge clk); stop = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b1) $display("[TB] FAIL stop_inflight_valid: got %0b expected 1", valid); else passes++;
        checks++;
        if (dout1 !== rom_word(model_addr(idx, stp)))
            $display("[TB] FAIL stop_inflight_dout1: got %0h expected %0h", dout1, rom_word(model_addr(idx, stp)));
        else passes++;
        @(negedge clk); stop = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0) $display("[TB] FAIL stop_no_issue: got %0b expected 0", valid); else passes++;
        checks++;
        if (busy !== 1'b1) $display("[TB] FAIL stop_drain_busy: got %0b expected 1", busy); else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b1) $display("[TB] FAIL stop_done: got %0b expected 1", done); else passes++;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL stop_busy_after: got %0b expected 0", busy); else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0) $display("[TB] FAIL stop_done_pulse: got %0b expected 0", done); else passes++;
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        start = 1'b1; step = 16'h0100 | 16'($urandom_range(0, 16'hFEFF)); phase = 8'h80 | 8'($urandom); count = 16'd0; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (valid !== 1'b1) $display("[TB] FAIL midrst_pre_valid: got %0b expected 1", valid); else passes++;
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0) $display("[TB] FAIL midrst_valid: got %0b expected 0", valid); else passes++;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %0b expected 0", busy); else passes++;
        checks++;
        if (addr1 !== 8'h00) $display("[TB] FAIL midrst_addr1: got %0h expected 0", addr1); else passes++;
        checks++;
        if (offset !== 8'h00) $display("[TB] FAIL midrst_offset: got %0h expected 0", offset); else passes++;
        checks++;
        if (done !== 1'b0) $display("[TB] FAIL midrst_done: got %0b expected 0", done); else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0) $display("[TB] FAIL midrst_done_next: got %0b expected 0", done); else passes++;
    endtask

    task automatic test_random();
        logic [15:0] stp;
        logic [7:0]  ph;
        int          n;
        int unsigned idx;
        int          k;
        int          done_k;
        int          last_acc;
        for (int it = 0; it < 20; it++) begin
            stp = 16'($urandom);
            ph  = 8'($urandom);
            n   = $urandom_range(1, 10);
            idx = 0; k = 0; done_k = 0; last_acc = -1;
            @(negedge clk);
            start = 1'b1; step = stp; phase = ph; count = 16'(n); ready = 1'b1;
            while (done_k == 0 && k < 200) begin
                k++;
                @(negedge clk);
                start = busy && ($urandom_range(0, 4) == 0);
                step  = 16'($urandom);
                phase = 8'($urandom);
                count = 16'($urandom);
                ready = ($urandom_range(0, 3) != 0);
                #1;
                if (busy) begin
                    checks++;
                    if (offset !== ph) $display("[TB] FAIL rnd_offset it=%0d k=%0d: got %0h expected %0h", it, k, offset, ph); else passes++;
                end
                if (valid && ready) begin
                    checks++;
                    if (dout1 !== rom_word(model_addr(idx, stp)))
                        $display("[TB] FAIL rnd_dout1 it=%0d idx=%0d: got %0h expected %0h", it, idx, dout1, rom_word(model_addr(idx, stp)));
                    else passes++;
                    checks++;
                    if (dout2 !== rom_word(model_addr(idx, stp) + ph))
                        $display("[TB] FAIL rnd_dout2 it=%0d idx=%0d: got %0h expected %0h", it, idx, dout2, rom_word(model_addr(idx, stp) + ph));
                    else passes++;
                    idx++;
                    last_acc = k;
                end
                if (done) done_k = k;
            end
            start = 1'b0;
            checks++;
            if (done_k == 0) $display("[TB] FAIL rnd_timeout it=%0d: got no done expected done", it); else passes++;
            checks++;
            if (idx != n) $display("[TB] FAIL rnd_count it=%0d: got %0d expected %0d", it, idx, n); else passes++;
            checks++;
            if (done_k != last_acc + 1) $display("[TB] FAIL rnd_done_cycle it=%0d: got %0d expected %0d", it, done_k, last_acc + 1); else passes++;
            checks++;
            if (valid !== 1'b0) $display("[TB] FAIL rnd_valid_at_done it=%0d: got %0b expected 0", it, valid); else passes++;
            checks++;
            if (busy !== 1'b0) $display("[TB] FAIL rnd_busy_at_done it=%0d: got %0b expected 0", it, busy); else passes++;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting sinegen_ctrl bench");
        test_reset();
        test_burst();
        test_fractional_wrap();
        test_backpressure();
        test_continuous_stop();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
